// File: rtl/reg_bank_2r1w.sv
// rtl/reg_bank_2r1w.sv - two-read one-write register bank with exported low registers
// Registered reads with write-first bypass, out-of-range flagging and synchronous clear.
module reg_bank_2r1w #(
  parameter int OP_WIDTH = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR     = 4,
  parameter int NUM_EXP  = 4,
  parameter logic [OP_WIDTH-1:0] RST_VAL2 = 'h81,
  parameter logic [OP_WIDTH-1:0] RST_VAL3 = 'h20
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Clr,
  input  logic                         WrEn,
  input  logic [ADDR-1:0]              WrAddr,
  input  logic [OP_WIDTH-1:0]          WrData,
  input  logic                         RdEnA,
  input  logic [ADDR-1:0]              RdAddrA,
  input  logic                         RdEnB,
  input  logic [ADDR-1:0]              RdAddrB,
  output logic [OP_WIDTH-1:0]          RdDataA,
  output logic [OP_WIDTH-1:0]          RdDataB,
  output logic                         RdValidA,
  output logic                         RdValidB,
  output logic                         AddrErr,
  output logic [NUM_EXP*OP_WIDTH-1:0]  REG_OUT
);

  localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);

  logic [OP_WIDTH-1:0] regs [DEPTH];
  logic [OP_WIDTH-1:0] mem_a, mem_b;
  logic                wr_ok, a_ok, b_ok;
  logic                byp_a, byp_b;
  logic [OP_WIDTH-1:0] nxt_a, nxt_b;
  logic                err_nxt;

  function automatic logic [OP_WIDTH-1:0] rst_val(input int idx);
    if (idx == 2)      return RST_VAL2;
    else if (idx == 3) return RST_VAL3;
    else               return '0;
  endfunction

  assign wr_ok = ({1'b0, WrAddr}  < DEPTH_L);
  assign a_ok  = ({1'b0, RdAddrA} < DEPTH_L);
  assign b_ok  = ({1'b0, RdAddrB} < DEPTH_L);

  // Address decode by loop keeps indexing in range when DEPTH < 2**ADDR.
  always_comb begin
    mem_a = '0;
    mem_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == ADDR'(i)) mem_a = regs[i];
      if (RdAddrB == ADDR'(i)) mem_b = regs[i];
    end
  end

  // A clear cancels the write, so it must also cancel the bypass.
  assign byp_a = WrEn && wr_ok && !Clr && (RdAddrA == WrAddr);
  assign byp_b = WrEn && wr_ok && !Clr && (RdAddrB == WrAddr);

  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    if (a_ok) nxt_a = byp_a ? WrData : mem_a;
    if (b_ok) nxt_b = byp_b ? WrData : mem_b;
  end

  assign err_nxt = (WrEn && !wr_ok) || (RdEnA && !a_ok) || (RdEnB && !b_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= rst_val(i);
    end else if (Clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= rst_val(i);
    end else if (WrEn && wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrAddr == ADDR'(i)) regs[i] <= WrData;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RdDataA  <= '0;
      RdDataB  <= '0;
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      RdValidA <= RdEnA;
      RdValidB <= RdEnB;
      AddrErr  <= err_nxt;
      if (RdEnA) RdDataA <= nxt_a;
      if (RdEnB) RdDataB <= nxt_b;
    end
  end

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
    assign REG_OUT[g*OP_WIDTH +: OP_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// tb/tb_reg_bank_2r1w.sv - directed vector bench for reg_bank_2r1w
module tb_reg_bank_2r1w;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Clr, WrEn, RdEnA, RdEnB;
  logic [3:0]  WrAddr, RdAddrA, RdAddrB;
  logic [7:0]  WrData;
  logic [7:0]  RdDataA, RdDataB;
  logic        RdValidA, RdValidB, AddrErr;
  logic [31:0] REG_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  reg_bank_2r1w #(.OP_WIDTH(8), .DEPTH(12), .ADDR(4), .NUM_EXP(4)) dut (
    .CLK(CLK), .RST(RST), .Clr(Clr),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
    .RdDataA(RdDataA), .RdDataB(RdDataB),
    .RdValidA(RdValidA), .RdValidB(RdValidB),
    .AddrErr(AddrErr), .REG_OUT(REG_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr, we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        ra;
    logic [3:0]  aa;
    logic        rb;
    logic [3:0]  ab;
    logic        eva;
    logic [7:0]  eda;
    logic        evb;
    logic [7:0]  edb;
    logic        eerr;
    logic [31:0] ereg;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic clr, logic we, logic [3:0] wa, logic [7:0] wd,
                              logic ra, logic [3:0] aa, logic rb, logic [3:0] ab,
                              logic eva, logic [7:0] eda, logic evb, logic [7:0] edb,
                              logic eerr, logic [31:0] ereg);
    vec_t v;
    v.clr = clr; v.we = we; v.wa = wa; v.wd = wd;
    v.ra = ra; v.aa = aa; v.rb = rb; v.ab = ab;
    v.eva = eva; v.eda = eda; v.evb = evb; v.edb = edb;
    v.eerr = eerr; v.ereg = ereg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    Clr = 0; WrEn = 0; WrAddr = 0; WrData = 0;
    RdEnA = 0; RdAddrA = 0; RdEnB = 0; RdAddrB = 0;
  endtask

  initial begin
    //               clr we wa     wd     ra aa     rb ab     va da     vb db     err reg_out
    vecs[0]  = mk(0, 0, 4'd0,  8'h00, 1, 4'd2,  1, 4'd3,  1, 8'h81, 1, 8'h20, 0, 32'h2081_0000);
    vecs[1]  = mk(0, 0, 4'd0,  8'h00, 0, 4'd0,  0, 4'd0,  0, 8'h81, 0, 8'h20, 0, 32'h2081_0000);
    vecs[2]  = mk(0, 1, 4'd5,  8'hA5, 1, 4'd5,  0, 4'd0,  1, 8'hA5, 0, 8'h20, 0, 32'h2081_0000);
    vecs[3]  = mk(0, 0, 4'd0,  8'h00, 0, 4'd0,  1, 4'd5,  0, 8'hA5, 1, 8'hA5, 0, 32'h2081_0000);
    vecs[4]  = mk(0, 1, 4'd12, 8'hFF, 0, 4'd0,  1, 4'd13, 0, 8'hA5, 1, 8'h00, 1, 32'h2081_0000);
    vecs[5]  = mk(0, 0, 4'd0,  8'h00, 0, 4'd0,  0, 4'd0,  0, 8'hA5, 0, 8'h00, 0, 32'h2081_0000);
    vecs[6]  = mk(0, 1, 4'd2,  8'h00, 0, 4'd0,  0, 4'd0,  0, 8'hA5, 0, 8'h00, 0, 32'h2000_0000);
    vecs[7]  = mk(1, 1, 4'd2,  8'h55, 1, 4'd2,  0, 4'd0,  1, 8'h00, 0, 8'h00, 0, 32'h2081_0000);
    vecs[8]  = mk(0, 1, 4'd0,  8'h3C, 1, 4'd5,  1, 4'd0,  1, 8'h00, 1, 8'h3C, 0, 32'h2081_003C);
    vecs[9]  = mk(0, 1, 4'd11, 8'h77, 1, 4'd11, 1, 4'd12, 1, 8'h77, 1, 8'h00, 1, 32'h2081_003C);
    vecs[10] = mk(0, 0, 4'd0,  8'h00, 1, 4'd11, 0, 4'd0,  1, 8'h77, 0, 8'h00, 0, 32'h2081_003C);
    vecs[11] = mk(0, 1, 4'd3,  8'h09, 1, 4'd1,  0, 4'd0,  1, 8'h00, 0, 8'h00, 0, 32'h0981_003C);
    vecs[12] = mk(0, 1, 4'd15, 8'hEE, 0, 4'd0,  0, 4'd0,  0, 8'h00, 0, 8'h00, 1, 32'h0981_003C);

    idle();
    RST = 1;
    #2;
    chk("rst_reg_out", REG_OUT, 32'h2081_0000);
    chk("rst_valid_a", {31'd0, RdValidA}, 0);
    chk("rst_valid_b", {31'd0, RdValidB}, 0);
    chk("rst_data_a", {24'd0, RdDataA}, 0);
    chk("rst_err", {31'd0, AddrErr}, 0);
    #6 RST = 0;
    @(posedge CLK); #1;

    for (int i = 0; i < 13; i++) begin
      Clr = vecs[i].clr; WrEn = vecs[i].we; WrAddr = vecs[i].wa; WrData = vecs[i].wd;
      RdEnA = vecs[i].ra; RdAddrA = vecs[i].aa; RdEnB = vecs[i].rb; RdAddrB = vecs[i].ab;
      @(posedge CLK); #1;
      chk($sformatf("v%0d_valid_a", i), {31'd0, RdValidA}, {31'd0, vecs[i].eva});
      chk($sformatf("v%0d_data_a", i), {24'd0, RdDataA}, {24'd0, vecs[i].eda});
      chk($sformatf("v%0d_valid_b", i), {31'd0, RdValidB}, {31'd0, vecs[i].evb});
      chk($sformatf("v%0d_data_b", i), {24'd0, RdDataB}, {24'd0, vecs[i].edb});
      chk($sformatf("v%0d_addr_err", i), {31'd0, AddrErr}, {31'd0, vecs[i].eerr});
      chk($sformatf("v%0d_reg_out", i), REG_OUT, vecs[i].ereg);
    end
    idle();

    // Reset while a read pulse is showing and another read is pending.
    RdEnA = 1; RdAddrA = 4'd2;
    @(posedge CLK); #1;
    chk("mid_pre_valid_a", {31'd0, RdValidA}, 1);
    chk("mid_pre_data_a", {24'd0, RdDataA}, 32'h81);
    #2 RST = 1;
    #1;
    chk("mid_rst_valid_a", {31'd0, RdValidA}, 0);
    chk("mid_rst_data_a", {24'd0, RdDataA}, 0);
    chk("mid_rst_reg_out", REG_OUT, 32'h2081_0000);
    #1 RST = 0; RdEnA = 0;
    @(posedge CLK); #1;
    chk("mid_post_valid_a", {31'd0, RdValidA}, 0);
    chk("mid_post_data_a", {24'd0, RdDataA}, 0);
    RdEnB = 1; RdAddrB = 4'd3;
    @(posedge CLK); #1;
    chk("first_after_rst_valid_b", {31'd0, RdValidB}, 1);
    chk("first_after_rst_data_b", {24'd0, RdDataB}, 32'h20);
    idle();
    @(posedge CLK); #1;
    chk("pulse_end_valid_b", {31'd0, RdValidB}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_bank_2r1w.md
REG_BANK_2R1W -- requirements
Module: reg_bank_2r1w

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 8: data width of every register and port.
REQ-002 SHALL have parameter DEPTH, default 16: number of registers, 2 <= DEPTH <= 2**ADDR.
REQ-003 SHALL have parameter ADDR, default 4: address width of all ports.
REQ-004 SHALL have parameter NUM_EXP, default 4: number of registers (index 0..NUM_EXP-1) exported on REG_OUT, 1 <= NUM_EXP <= DEPTH.
REQ-005 SHALL have parameters RST_VAL2, default 'h81, and RST_VAL3, default 'h20: reset values of registers 2 and 3; all other registers reset to 0.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, ports CLK and RST.
REQ-007 CLK  in  1  rising-edge clock for all state.
REQ-008 RST  in  1  asynchronous active-high reset.
REQ-009 Clr  in  1  synchronous restore of all registers to reset values.
REQ-010 WrEn  in  1  write request.
REQ-011 WrAddr  in  ADDR  write address.
REQ-012 WrData  in  OP_WIDTH  write data.
REQ-013 RdEnA / RdEnB  in  1  read request, port A / port B.
REQ-014 RdAddrA / RdAddrB  in  ADDR  read address, port A / port B.
REQ-015 RdDataA / RdDataB  out  OP_WIDTH  registered read data.
REQ-016 RdValidA / RdValidB  out  1  read data valid, one-cycle pulse.
REQ-017 AddrErr  out  1  one-cycle pulse: an enabled access used an address >= DEPTH.
REQ-018 REG_OUT  out  NUM_EXP*OP_WIDTH  live contents of registers 0..NUM_EXP-1; register i on bits [i*OP_WIDTH +: OP_WIDTH].

Function
REQ-019 Write: WrEn high with WrAddr < DEPTH SHALL update that register at the rising edge; the new value SHALL appear on REG_OUT in the next cycle.
REQ-020 Read: RdEnX high at edge N SHALL load RdDataX and set RdValidX high for the cycle after edge N (latency 1).
REQ-021 RdValidX SHALL be low in every cycle not following a RdEnX edge; RdDataX SHALL hold its last value while RdEnX is low.
REQ-022 Ports A and B SHALL be fully independent; both may read the same or different addresses in the same cycle.
REQ-023 Read and write in the same cycle SHALL both be performed (no mutual exclusion); both ports stay usable during a write.
REQ-024 Same-address collision (RdAddrX == WrAddr, both enabled, address valid): RdDataX SHALL return WrData (write-first bypass).
REQ-025 Out-of-range write (WrAddr >= DEPTH): SHALL be ignored; AddrErr SHALL pulse high the next cycle.
REQ-026 Out-of-range read: RdDataX SHALL load 0, RdValidX SHALL still pulse, AddrErr SHALL pulse the next cycle.
REQ-027 AddrErr SHALL be the OR of all simultaneous out-of-range conditions, single pulse per offending cycle.
REQ-028 Clr high SHALL restore all registers to reset values at the edge and SHALL take priority over a same-cycle write (write discarded).
REQ-029 A read issued in the same cycle as Clr SHALL return pre-clear contents, with no bypass of WrData.
REQ-030 Clr SHALL NOT affect RdDataX, RdValidX or AddrErr.

Reset
REQ-031 While RST is high: registers SHALL hold reset values (reg2 = RST_VAL2, reg3 = RST_VAL3, others 0), RdDataA/B = 0, RdValidA/B = 0, AddrErr = 0, immediately and without a clock.
REQ-032 RST asserted mid-operation SHALL abort pending read-valid pulses; the first access is accepted at the first rising edge after RST deasserts.

Verification
REQ-033 Reset: assert RST, no clock -> REG_OUT = {8'h20,8'h81,8'h00,8'h00} (reg3..reg0), RdValidA/B = 0.
REQ-034 Dual read: RdEnA@2, RdEnB@3 in one cycle -> next cycle RdDataA = 8'h81, RdDataB = 8'h20, both valid for exactly one cycle.
REQ-035 Collision: WrEn, WrAddr=5, WrData=8'hA5, RdEnA, RdAddrA=5 -> next cycle RdDataA = 8'hA5, RdValidA = 1; a later read of 5 returns 8'hA5.
REQ-036 Out of range (DEPTH=12): write 12 with 8'hFF and read B at 13 -> AddrErr one pulse, RdDataB = 0, RdValidB = 1, no register changes.
REQ-037 Clear: write reg2 = 8'h00, then Clr with WrEn@2 = 8'h55 and RdEnA@2 -> RdDataA = 8'h00, reg2 = 8'h81 afterwards.
REQ-038 Reset mid-read: RdEnA high, RST pulsed before the next edge -> RdValidA stays 0, RdDataA = 0.
